// File: rtl/ysyx_23060059_ifu_pkg.sv
// Shared types and AXI constants for the instruction prefetch unit.
package ysyx_23060059_ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } ifu_state_e;

    localparam logic [3:0] ARID      = 4'd0;
    localparam logic [7:0] ARLEN     = 8'd0;
    localparam logic [2:0] ARSIZE    = 3'b010;
    localparam logic [1:0] ARBURST   = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ysyx_23060059_fetch_fifo.sv
// Small power-of-two FIFO holding fetched instructions; flush clears it in one cycle.
module ysyx_23060059_fetch_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ysyx_23060059_ifu_prefetch.sv
// Instruction fetch unit: single-outstanding AXI reader feeding a prefetch FIFO to the IDU.
module ysyx_23060059_ifu_prefetch
    import ysyx_23060059_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DATA_W   = 64,
    parameter int          DEPTH    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              arready,
    output logic              arvalid,
    output logic [31:0]       araddr,
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [3:0]        rid,
    output logic              rready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic              out_fault
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    ifu_state_e   state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic [31:0]  araddr_q;
    logic         arvalid_q;
    logic         stale;
    logic         ar_fire;
    logic         r_fire;
    logic         resp_ok;
    logic [31:0]  lane;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] count;
    logic         room_req;
    logic         room_pre;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic         unused;

    assign arid    = ARID;
    assign arlen   = ARLEN;
    assign arsize  = ARSIZE;
    assign arburst = ARBURST;
    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign rready  = (state == S_WAIT);

    assign ar_fire = arvalid_q && arready;
    assign r_fire  = rvalid && rready;
    assign resp_ok = (rresp == RESP_OKAY);

    generate
        if (DATA_W == 64) begin : g_lane64
            assign lane = req_pc[2] ? rdata[63:32] : rdata[31:0];
        end else begin : g_lane32
            assign lane = rdata[31:0];
        end
    endgenerate

    assign push_entry = '{pc: req_pc, inst: lane, fault: !resp_ok};
    assign push       = r_fire && !stale && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;

    // Room for one more read: in REQ nothing is in flight; when re-arming from
    // WAIT the response being pushed this cycle already occupies a slot.
    assign room_req = (count < DEPTH_C);
    assign room_pre = pop ? (count < DEPTH_C) : (count < DEPTH_M1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            stale     <= 1'b0;
        end else begin
            if (ar_fire) begin
                req_pc    <= araddr_q;
                arvalid_q <= 1'b0;
            end

            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                // A response accepted this very cycle is no longer pending.
                stale    <= arvalid_q || (state == S_WAIT && !rvalid);
            end else begin
                if (ar_fire && !stale) fetch_pc <= next_pc(fetch_pc);
                if (r_fire && stale)   stale    <= 1'b0;

                if (state == S_REQ && !arvalid_q && room_req) begin
                    arvalid_q <= 1'b1;
                    araddr_q  <= fetch_pc;
                end else if (state == S_WAIT && r_fire && !stale && resp_ok && room_pre) begin
                    arvalid_q <= 1'b1;
                    araddr_q  <= fetch_pc;
                end
            end

            case (state)
                S_IDLE:  state <= S_REQ;
                S_REQ:   if (ar_fire) state <= S_WAIT;
                S_WAIT:  if (r_fire) state <= (stale || redirect_valid || resp_ok) ? S_REQ : S_HALT;
                S_HALT:  if (redirect_valid) state <= S_REQ;
                default: state <= S_IDLE;
            endcase
        end
    end

    ysyx_23060059_fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign out_valid = !fifo_empty;
    assign out_inst  = fifo_empty ? 32'd0 : head.inst;
    assign out_pc    = fifo_empty ? 32'd0 : head.pc;
    assign out_fault = !fifo_empty && head.fault;

    assign unused = ^{rlast, rid, fifo_full};

endmodule

// File: tb/tb_ysyx_23060059_ifu_prefetch.sv
// Directed bench for the prefetch IFU with a one-outstanding AXI memory model.
module tb_ysyx_23060059_ifu_prefetch;
    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // memory model knobs
    int          lat = 1;
    logic        fixed = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        pend = 1'b0;
    logic [31:0] pa;
    int          wcnt;

    logic [31:0] hs_addr[$];
    int          hs_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    logic        pop_fault[$];

    ysyx_23060059_ifu_prefetch dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
        .rready(rready), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_fault(out_fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory: respond lat cycles after the AR handshake; 64-bit word holds {inst(A+4), inst(A)}.
    initial begin
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
        forever begin
            @(negedge clock); #2;
            rvalid = 1'b0;
            rresp  = 2'b00;
            if (reset) pend = 1'b0;
            else if (pend) begin
                if (wcnt == 0) begin
                    rvalid = 1'b1;
                    rdata  = fixed ? 64'h1111_1111_2222_2222 : {~(pa | 32'h4), ~(pa & ~32'h4)};
                    rresp  = (pa == err_addr) ? 2'b10 : 2'b00;
                    pend   = 1'b0;
                end else wcnt--;
            end
            if (!reset && arvalid && arready) begin
                pend = 1'b1;
                pa   = araddr;
                wcnt = lat - 1;
            end
        end
    end

    initial forever begin
        @(negedge clock); #2;
        if (!reset) begin
            if (arvalid && arready) begin
                hs_addr.push_back(araddr);
                hs_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                pop_pc.push_back(out_pc);
                pop_inst.push_back(out_inst);
                pop_fault.push_back(out_fault);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_q();
        hs_addr.delete(); hs_cyc.delete();
        pop_pc.delete(); pop_inst.delete(); pop_fault.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        run(3);
        clear_q();
        reset = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clock);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; arready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        run(3);
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", rready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (arid !== 4'd0) begin errors++; $display("FAIL arid: got %h want 0", arid); end
        checks++; if (arlen !== 8'd0) begin errors++; $display("FAIL arlen: got %h want 0", arlen); end
        checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL arsize: got %b want 010", arsize); end
        checks++; if (arburst !== 2'b01) begin errors++; $display("FAIL arburst: got %b want 01", arburst); end
    endtask

    task automatic test_seq();
        int first_ar = 0;
        int first_ov = 0;
        lat = 1; arready = 1'b1; out_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (arvalid && first_ar == 0) first_ar = k;
            if (out_valid && first_ov == 0) first_ov = k;
        end
        checks++; if (first_ar != 2) begin errors++; $display("FAIL first_ar_cycle: got %0d want 2", first_ar); end
        checks++; if (first_ov != 4) begin errors++; $display("FAIL latency: got %0d want 4", first_ov); end
        checks++;
        if (hs_addr.size() < 3 || pop_pc.size() < 3) begin
            errors++; $display("FAIL seq_count: got hs=%0d pops=%0d want >=3", hs_addr.size(), pop_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (hs_addr[i] !== 32'h8000_0000 + 32'(4 * i)) begin
                    errors++; $display("FAIL seq_araddr[%0d]: got %h want %h", i, hs_addr[i], 32'h8000_0000 + 32'(4 * i)); end
                checks++; if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i)) begin
                    errors++; $display("FAIL seq_out_pc[%0d]: got %h want %h", i, pop_pc[i], 32'h8000_0000 + 32'(4 * i)); end
                checks++; if (pop_inst[i] !== ~(32'h8000_0000 + 32'(4 * i))) begin
                    errors++; $display("FAIL seq_out_inst[%0d]: got %h want %h", i, pop_inst[i], ~(32'h8000_0000 + 32'(4 * i))); end
            end
            checks++; if (hs_cyc[2] - hs_cyc[1] != 2) begin
                errors++; $display("FAIL throughput: got %0d cycles want 2", hs_cyc[2] - hs_cyc[1]); end
        end
    endtask

    task automatic test_backpressure();
        lat = 1; out_ready = 1'b0;
        do_reset();
        run(30);
        checks++; if (hs_addr.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", hs_addr.size()); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL bp_arvalid: got %b want 0", arvalid); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000) begin
            errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=80000000", out_valid, out_pc); end
        checks++; if (out_inst !== 32'h7FFF_FFFF) begin errors++; $display("FAIL bp_inst: got %h want 7fffffff", out_inst); end
        out_ready = 1'b1;
        run(10);
        checks++;
        if (hs_addr.size() < 5 || pop_pc.size() < 5) begin
            errors++; $display("FAIL bp_resume: got hs=%0d pops=%0d want >=5", hs_addr.size(), pop_pc.size());
        end else begin
            checks++; if (hs_addr[4] !== 32'h8000_0010) begin errors++; $display("FAIL bp_resume_addr: got %h want 80000010", hs_addr[4]); end
            for (int i = 0; i < 5; i++) begin
                checks++; if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i)) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, pop_pc[i], 32'h8000_0000 + 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_flush();
        int n;
        lat = 1; out_ready = 1'b0;
        do_reset();
        run(20);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b want 1", out_valid); end
        pulse_redirect(32'h8000_0200);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", out_valid); end
        n = hs_addr.size();
        run(10);
        checks++; if (hs_addr.size() <= n || hs_addr[n] !== 32'h8000_0200) begin
            errors++; $display("FAIL flush_addr: got %h want 80000200", (hs_addr.size() > n) ? hs_addr[n] : 32'hx); end
        out_ready = 1'b1;
        run(10);
        checks++; if (pop_pc.size() == 0 || pop_pc[0] !== 32'h8000_0200) begin
            errors++; $display("FAIL flush_pop: got %h want 80000200", (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
    endtask

    task automatic test_redirect_wait();
        logic found = 1'b0;
        int n;
        lat = 4; out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (arvalid && arready) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rw_hs: got %b want 1", found); end
        @(negedge clock);
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rw_in_wait: got %b want 1", rready); end
        n = hs_addr.size();
        pulse_redirect(32'h8000_1000);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_empty: got %b want 0", out_valid); end
        run(20);
        checks++; if (hs_addr.size() <= n || hs_addr[n] !== 32'h8000_1000) begin
            errors++; $display("FAIL rw_addr: got %h want 80001000", (hs_addr.size() > n) ? hs_addr[n] : 32'hx); end
        checks++; if (pop_pc.size() == 0 || pop_pc[0] !== 32'h8000_1000 || pop_inst[0] !== 32'h7FFF_EFFF) begin
            errors++; $display("FAIL rw_stale_drop: got pc=%h inst=%h want 80001000/7fffefff",
                (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, (pop_inst.size() > 0) ? pop_inst[0] : 32'hx); end
        lat = 1;
    endtask

    task automatic test_lane();
        lat = 1; fixed = 1'b1; out_ready = 1'b1;
        do_reset();
        pulse_redirect(32'h8000_0004);
        run(15);
        checks++;
        if (pop_pc.size() < 2) begin
            errors++; $display("FAIL lane_count: got %0d want >=2", pop_pc.size());
        end else begin
            checks++; if (pop_pc[0] !== 32'h8000_0004 || pop_inst[0] !== 32'h1111_1111) begin
                errors++; $display("FAIL lane_hi: got pc=%h inst=%h want 80000004/11111111", pop_pc[0], pop_inst[0]); end
            checks++; if (pop_pc[1] !== 32'h8000_0008 || pop_inst[1] !== 32'h2222_2222) begin
                errors++; $display("FAIL lane_lo: got pc=%h inst=%h want 80000008/22222222", pop_pc[1], pop_inst[1]); end
        end
        fixed = 1'b0;
    endtask

    task automatic test_fault();
        lat = 1; out_ready = 1'b1; err_addr = 32'h8000_0008;
        do_reset();
        run(20);
        checks++; if (hs_addr.size() != 3) begin errors++; $display("FAIL fault_hs: got %0d want 3", hs_addr.size()); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL fault_arvalid: got %b want 0", arvalid); end
        checks++;
        if (pop_pc.size() != 3) begin
            errors++; $display("FAIL fault_pops: got %0d want 3", pop_pc.size());
        end else begin
            checks++; if (pop_pc[2] !== 32'h8000_0008 || pop_fault[2] !== 1'b1) begin
                errors++; $display("FAIL fault_entry: got pc=%h f=%b want 80000008/1", pop_pc[2], pop_fault[2]); end
            checks++; if (pop_fault[0] !== 1'b0 || pop_fault[1] !== 1'b0) begin
                errors++; $display("FAIL fault_clean: got %b%b want 00", pop_fault[0], pop_fault[1]); end
        end
        err_addr = 32'hFFFF_FFFF;
        pulse_redirect(32'h8000_0100);
        run(10);
        checks++; if (hs_addr.size() < 4 || hs_addr[3] !== 32'h8000_0100) begin
            errors++; $display("FAIL fault_resume: got %h want 80000100", (hs_addr.size() > 3) ? hs_addr[3] : 32'hx); end
        checks++; if (pop_pc.size() < 4 || pop_pc[3] !== 32'h8000_0100 || pop_fault[3] !== 1'b0) begin
            errors++; $display("FAIL fault_resume_pop: got %h want 80000100", (pop_pc.size() > 3) ? pop_pc[3] : 32'hx); end
    endtask

    task automatic test_reset_wait();
        logic found = 1'b0;
        lat = 4; out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (arvalid && arready) found = 1'b1;
        end
        @(negedge clock);
        checks++; if (rready !== 1'b1 || found !== 1'b1) begin
            errors++; $display("FAIL rstw_wait: got rready=%b found=%b want 1/1", rready, found); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({arvalid, rready, out_valid, out_fault} !== 4'b0 || araddr !== 32'd0 ||
                      out_pc !== 32'd0 || out_inst !== 32'd0) begin
            errors++; $display("FAIL rstw_outputs: got ar=%b rr=%b ov=%b f=%b a=%h pc=%h i=%h want all 0",
                arvalid, rready, out_valid, out_fault, araddr, out_pc, out_inst); end
        lat = 1;
        run(2);
        clear_q();
        reset = 1'b0;
        run(12);
        checks++; if (hs_addr.size() == 0 || hs_addr[0] !== 32'h8000_0000) begin
            errors++; $display("FAIL rstw_first_addr: got %h want 80000000", (hs_addr.size() > 0) ? hs_addr[0] : 32'hx); end
        checks++; if (pop_pc.size() == 0 || pop_pc[0] !== 32'h8000_0000) begin
            errors++; $display("FAIL rstw_first_pop: got %h want 80000000", (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        arready = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        test_reset();
        test_seq();
        test_backpressure();
        test_flush();
        test_redirect_wait();
        test_lane();
        test_fault();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
